// File: rtl/mac_alu_pipe.sv
// mac_alu_pipe: two-stage pipelined, multi-channel multiply-accumulate ALU.
//
// Executes the alu_cmd_t command set against one of NCH internal accumulators
// selected per beat. S1 registers the command, channel, clear, operands and the
// full-width product; S2 reads acc[ch], computes the result, registers the outputs
// and writes acc[ch] back on the same edge.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   valid_in / ready_out  input beat handshake
//   ch_in, cmd_in, clr_in channel select, operation, per-beat accumulator clear
//   m1_in, m2_in          signed operands
//   valid_out / ready_in  result beat handshake
//   ch_out, d_out         channel and result of the output beat
//   ovf_out               sticky overflow flag of ch_out, including this beat
//   sat_out               SATA clamp applied on this beat

package myfilter_pkg;

  parameter int unsigned DATABITS = 16;
  parameter int unsigned ACCBITS  = 40;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_M1   = 5'd1,
    ALU_M2   = 5'd2,
    ALU_MU   = 5'd3,
    ALU_ACN  = 5'd4,
    ALU_M1N  = 5'd5,
    ALU_M2N  = 5'd6,
    ALU_MUN  = 5'd7,
    ALU_ADAC = 5'd8,
    ALU_ADM1 = 5'd9,
    ALU_ADM2 = 5'd10,
    ALU_ADMU = 5'd11,
    ALU_SUAC = 5'd12,
    ALU_SUM1 = 5'd13,
    ALU_SUM2 = 5'd14,
    ALU_SUMU = 5'd15,
    ALU_SATA = 5'd16
  } alu_cmd_t;

endpackage

module mac_alu_pipe #(
  parameter int unsigned DATABITS = myfilter_pkg::DATABITS,
  parameter int unsigned ACCBITS  = myfilter_pkg::ACCBITS,
  parameter int unsigned NCH      = 4,
  localparam int unsigned CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [CHW-1:0]         ch_in,
  input  myfilter_pkg::alu_cmd_t cmd_in,
  input  logic                   clr_in,
  input  logic [DATABITS-1:0]    m1_in,
  input  logic [DATABITS-1:0]    m2_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [CHW-1:0]         ch_out,
  output logic [ACCBITS-1:0]     d_out,
  output logic                   ovf_out,
  output logic                   sat_out
);

  localparam int unsigned Msb = ACCBITS - 1;
  // SATA clamp bounds, sign-extended to the accumulator width.
  localparam logic signed [ACCBITS-1:0] SatMax =
    {{(ACCBITS - DATABITS + 1){1'b0}}, {(DATABITS - 1){1'b1}}};
  localparam logic signed [ACCBITS-1:0] SatMin = ~SatMax;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic valid_q;
  logic adv;

  assign adv       = ~valid_q | ready_in;
  assign ready_out = adv;

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic                          s1_valid_q;
  myfilter_pkg::alu_cmd_t        s1_cmd_q;
  logic [CHW-1:0]                s1_ch_q;
  logic                          s1_clr_q;
  logic signed [DATABITS-1:0]    s1_m1_q;
  logic signed [DATABITS-1:0]    s1_m2_q;
  logic signed [2*DATABITS-1:0]  s1_prod_q;
  logic signed [2*DATABITS-1:0]  prod_d;

  assign prod_d = (2*DATABITS)'($signed(m1_in)) * (2*DATABITS)'($signed(m2_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cmd_q   <= myfilter_pkg::ALU_NOP;
      s1_ch_q    <= '0;
      s1_clr_q   <= 1'b0;
      s1_m1_q    <= '0;
      s1_m2_q    <= '0;
      s1_prod_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_cmd_q  <= cmd_in;
        s1_ch_q   <= ch_in;
        s1_clr_q  <= clr_in;
        s1_m1_q   <= $signed(m1_in);
        s1_m2_q   <= $signed(m2_in);
        s1_prod_q <= prod_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulator read, ALU, writeback
  // ---------------------------------------------------------------------------
  logic signed [ACCBITS-1:0] acc_q [NCH];
  logic [NCH-1:0]            acc_ovf_q;

  logic signed [ACCBITS-1:0] acc_rd;
  logic                      ovf_rd;
  logic signed [ACCBITS-1:0] a;
  logic                      ovf_base;
  logic signed [ACCBITS-1:0] m1x, m2x, px;
  logic signed [ACCBITS-1:0] lhs, rhs, sum, sata_shift;
  logic                      do_sub, is_arith, is_sata, arith_ovf;
  logic signed [ACCBITS-1:0] res;
  logic                      res_ovf, res_sat, wr_en;

  always_comb begin
    acc_rd = '0;
    ovf_rd = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (s1_ch_q == CHW'(i)) begin
        acc_rd = acc_q[i];
        ovf_rd = acc_ovf_q[i];
      end
    end
  end

  assign a        = s1_clr_q ? '0 : acc_rd;
  assign ovf_base = ~s1_clr_q & ovf_rd;
  assign m1x      = ACCBITS'(s1_m1_q);
  assign m2x      = ACCBITS'(s1_m2_q);
  assign px       = ACCBITS'(s1_prod_q);

  // Every arithmetic command is expressed as lhs +/- rhs so one adder and one
  // overflow detector cover add, subtract, negate (0 - x) and doubling.
  always_comb begin
    lhs      = '0;
    rhs      = '0;
    do_sub   = 1'b0;
    is_arith = 1'b1;
    is_sata  = 1'b0;
    case (s1_cmd_q)
      myfilter_pkg::ALU_NOP:  lhs = a;
      myfilter_pkg::ALU_M1:   rhs = m1x;
      myfilter_pkg::ALU_M2:   rhs = m2x;
      myfilter_pkg::ALU_MU:   rhs = px;
      myfilter_pkg::ALU_ACN:  begin rhs = a;   do_sub = 1'b1; end
      myfilter_pkg::ALU_M1N:  begin rhs = m1x; do_sub = 1'b1; end
      myfilter_pkg::ALU_M2N:  begin rhs = m2x; do_sub = 1'b1; end
      myfilter_pkg::ALU_MUN:  begin rhs = px;  do_sub = 1'b1; end
      myfilter_pkg::ALU_ADAC: begin lhs = a; rhs = a;   end
      myfilter_pkg::ALU_ADM1: begin lhs = a; rhs = m1x; end
      myfilter_pkg::ALU_ADM2: begin lhs = a; rhs = m2x; end
      myfilter_pkg::ALU_ADMU: begin lhs = a; rhs = px;  end
      myfilter_pkg::ALU_SUAC: begin lhs = a; rhs = a;   do_sub = 1'b1; end
      myfilter_pkg::ALU_SUM1: begin lhs = a; rhs = m1x; do_sub = 1'b1; end
      myfilter_pkg::ALU_SUM2: begin lhs = a; rhs = m2x; do_sub = 1'b1; end
      myfilter_pkg::ALU_SUMU: begin lhs = a; rhs = px;  do_sub = 1'b1; end
      myfilter_pkg::ALU_SATA: begin is_arith = 1'b0; is_sata = 1'b1; end
      default:                is_arith = 1'b0;
    endcase
  end

  assign sum        = do_sub ? (lhs - rhs) : (lhs + rhs);
  assign arith_ovf  = do_sub ? ((lhs[Msb] != rhs[Msb]) && (sum[Msb] != lhs[Msb]))
                             : ((lhs[Msb] == rhs[Msb]) && (sum[Msb] != lhs[Msb]));
  assign sata_shift = a >>> (DATABITS - 1);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_sat = 1'b0;
    wr_en   = 1'b0;
    if (is_arith) begin
      res     = sum;
      res_ovf = arith_ovf;
      wr_en   = 1'b1;
    end else if (is_sata) begin
      if (sata_shift > SatMax) begin
        res     = SatMax;
        res_sat = 1'b1;
      end else if (sata_shift < SatMin) begin
        res     = SatMin;
        res_sat = 1'b1;
      end else begin
        res = sata_shift;
      end
    end else begin
      // Undefined code: result 0, accumulator only touched to honour a clear.
      wr_en = s1_clr_q;
    end
  end

  logic [CHW-1:0]     ch_q;
  logic [ACCBITS-1:0] d_q;
  logic               ovf_q, sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ch_q      <= '0;
      d_q       <= '0;
      ovf_q     <= 1'b0;
      sat_q     <= 1'b0;
      acc_ovf_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0;
      end
    end else if (adv) begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ch_q  <= s1_ch_q;
        d_q   <= res;
        ovf_q <= ovf_base | res_ovf;
        sat_q <= res_sat;
        for (int i = 0; i < NCH; i++) begin
          if (s1_ch_q == CHW'(i)) begin
            acc_ovf_q[i] <= ovf_base | res_ovf;
            if (wr_en) begin
              acc_q[i] <= res;
            end
          end
        end
      end
    end
  end

  assign valid_out = valid_q;
  assign ch_out    = ch_q;
  assign d_out     = d_q;
  assign ovf_out   = ovf_q;
  assign sat_out   = sat_q;

endmodule

// File: tb/tb_mac_alu_pipe.sv
// Self-checking bench for mac_alu_pipe (DATABITS=16, ACCBITS=40, NCH=4).
// A behavioural model computes each beat's expected result at drive time and
// pushes it to a scoreboard; a monitor pops and compares every delivered beat.
module tb_mac_alu_pipe;
  import myfilter_pkg::*;

  localparam int unsigned DB = 16;
  localparam int unsigned AB = 40;
  localparam int unsigned NC = 4;
  localparam int unsigned CW = 2;
  localparam longint AMAX = (64'sd1 <<< (AB - 1)) - 64'sd1;
  localparam longint AMIN = -AMAX - 64'sd1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in, ready_out, clr_in, valid_out, ready_in, ovf_out, sat_out;
  logic [CW-1:0] ch_in, ch_out;
  alu_cmd_t      cmd_in;
  logic [DB-1:0] m1_in, m2_in;
  logic [AB-1:0] d_out;

  mac_alu_pipe #(.DATABITS(DB), .ACCBITS(AB), .NCH(NC)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .ch_in(ch_in), .cmd_in(cmd_in), .clr_in(clr_in), .m1_in(m1_in), .m2_in(m2_in),
    .valid_out(valid_out), .ready_in(ready_in), .ch_out(ch_out), .d_out(d_out),
    .ovf_out(ovf_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [AB-1:0] d;
    logic          ovf;
    logic          sat;
  } beat_t;

  beat_t  exp_q[$];
  beat_t  got_q[$];
  int     got_cyc[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  longint m_acc[NC];
  bit     m_ovf[NC];
  beat_t  mon_b, mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    logic [AB-1:0] t;
    t = x[AB-1:0];
    return longint'(signed'(t));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // Drive one beat, wait for acceptance, and push the model's expected result.
  task automatic send(input int ch, input alu_cmd_t cmd, input bit clr,
                      input logic [DB-1:0] m1, input logic [DB-1:0] m2);
    longint a, p1, p2, pm, r;
    bit     ob, ovt, sat, wr;
    int     guard;
    beat_t  e;
    @(negedge clk);
    valid_in = 1'b1;
    ch_in    = ch[CW-1:0];
    cmd_in   = cmd;
    clr_in   = clr;
    m1_in    = m1;
    m2_in    = m2;
    #4;
    guard = 0;
    while (!ready_out && guard < 100) begin
      @(negedge clk);
      #4;
      guard++;
    end
    check("accept", ready_out, 1);
    a   = clr ? 0 : m_acc[ch];
    ob  = clr ? 1'b0 : m_ovf[ch];
    p1  = longint'(signed'(m1));
    p2  = longint'(signed'(m2));
    pm  = p1 * p2;
    sat = 1'b0;
    wr  = 1'b1;
    case (cmd)
      ALU_NOP:  r = a;
      ALU_M1:   r = p1;
      ALU_M2:   r = p2;
      ALU_MU:   r = pm;
      ALU_ACN:  r = -a;
      ALU_M1N:  r = -p1;
      ALU_M2N:  r = -p2;
      ALU_MUN:  r = -pm;
      ALU_ADAC: r = a + a;
      ALU_ADM1: r = a + p1;
      ALU_ADM2: r = a + p2;
      ALU_ADMU: r = a + pm;
      ALU_SUAC: r = 0;
      ALU_SUM1: r = a - p1;
      ALU_SUM2: r = a - p2;
      ALU_SUMU: r = a - pm;
      ALU_SATA: begin
        wr = 1'b0;
        r  = a >>> (DB - 1);
        if (r > 32767) begin
          r = 32767;
          sat = 1'b1;
        end else if (r < -32768) begin
          r = -32768;
          sat = 1'b1;
        end
      end
      default: begin
        r  = 0;
        wr = clr;
      end
    endcase
    ovt = (r > AMAX) || (r < AMIN);
    r   = wrap(r);
    if (wr) m_acc[ch] = r;
    m_ovf[ch] = ob | ovt;
    e.ch  = ch[CW-1:0];
    e.d   = r[AB-1:0];
    e.ovf = ob | ovt;
    e.sat = sat;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic clear_got();
    got_q.delete();
    got_cyc.delete();
  endtask

  // Monitor: sample just before the active edge, when handshake signals are settled.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && valid_out && ready_in) begin
      mon_b = {ch_out, d_out, ovf_out, sat_out};
      got_q.push_back(mon_b);
      got_cyc.push_back(cyc);
      check("scoreboard_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("scoreboard", mon_b, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    ch_in    = '0;
    cmd_in   = ALU_NOP;
    clr_in   = 1'b0;
    m1_in    = '0;
    m2_in    = '0;
    model_reset();
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_d", d_out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_ch", ch_out, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_sat", sat_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // MAC and scale on ch0
    clear_got();
    send(0, ALU_MU, 1'b1, 16'h4000, 16'h4000);
    send(0, ALU_ADMU, 1'b0, 16'h4000, 16'h4000);
    send(0, ALU_SATA, 1'b0, 16'h0000, 16'h0000);
    idle();
    drain();
    check("mac_mu", got_q[0].d, 40'h10000000);
    check("mac_admu", got_q[1].d, 40'h20000000);
    check("mac_sata", got_q[2].d, 40'h4000);
    check("mac_sata_flag", got_q[2].sat, 0);

    // Saturation on ch1
    clear_got();
    send(1, ALU_MU, 1'b1, 16'h8000, 16'h8000);
    send(1, ALU_ADMU, 1'b0, 16'h8000, 16'h8000);
    send(1, ALU_SATA, 1'b0, 16'h0000, 16'h0000);
    send(1, ALU_NOP, 1'b0, 16'h0000, 16'h0000);
    idle();
    drain();
    check("sat_admu", got_q[1].d, 40'h80000000);
    check("sat_sata", got_q[2].d, 40'h7FFF);
    check("sat_flag", got_q[2].sat, 1);
    check("sat_nop", got_q[3].d, 40'h80000000);
    check("sat_nop_flag", got_q[3].sat, 0);

    // Interleaved channels, back-to-back
    send(0, ALU_NOP, 1'b1, 16'h0, 16'h0);
    send(1, ALU_NOP, 1'b1, 16'h0, 16'h0);
    idle();
    drain();
    clear_got();
    send(0, ALU_ADM1, 1'b0, 16'd5, 16'h0);
    send(1, ALU_ADM1, 1'b0, 16'd7, 16'h0);
    send(0, ALU_ADM1, 1'b0, 16'd5, 16'h0);
    send(1, ALU_ADM1, 1'b0, 16'd7, 16'h0);
    idle();
    drain();
    check("il_0", got_q[0].d, 5);
    check("il_1", got_q[1].d, 7);
    check("il_2", got_q[2].d, 10);
    check("il_3", got_q[3].d, 14);
    for (int i = 1; i < 4; i++) check("il_gap", got_cyc[i] - got_cyc[i-1], 1);

    // Backpressure: ready_in low for three cycles mid-stream on ch3
    clear_got();
    fork
      begin
        send(3, ALU_ADM1, 1'b1, 16'd1, 16'h0);
        for (int i = 2; i <= 6; i++) send(3, ALU_ADM1, 1'b0, DB'(i), 16'h0);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        ready_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
          if (k != 0) @(negedge clk);
          #4;
          check("bp_ready_low", ready_out, 0);
          check("bp_hold", {ch_out, d_out, ovf_out, sat_out}, exp_q[0]);
        end
        @(negedge clk);
        ready_in = 1'b1;
        #4;
        check("bp_ready_high", ready_out, 1);
      end
    join
    drain();
    check("bp_count", got_q.size(), 6);
    check("bp_last", got_q[5].d, 21);

    // Overflow on ch2: 0x4000 doubled 25 times wraps to the most negative value
    clear_got();
    send(2, ALU_M1, 1'b1, 16'h4000, 16'h0);
    repeat (25) send(2, ALU_ADAC, 1'b0, 16'h0, 16'h0);
    send(2, ALU_NOP, 1'b0, 16'h0, 16'h0);
    send(2, ALU_NOP, 1'b1, 16'h0, 16'h0);
    idle();
    drain();
    check("ovf_24_d", got_q[24].d, 40'h4000000000);
    check("ovf_24_flag", got_q[24].ovf, 0);
    check("ovf_25_d", got_q[25].d, 40'h8000000000);
    check("ovf_25_flag", got_q[25].ovf, 1);
    check("ovf_nop_flag", got_q[26].ovf, 1);
    check("ovf_clr_d", got_q[27].d, 0);
    check("ovf_clr_flag", got_q[27].ovf, 0);

    // Undefined codes: zero result, accumulator kept unless cleared
    clear_got();
    send(0, alu_cmd_t'(5'd21), 1'b0, 16'd3, 16'd3);
    send(0, ALU_NOP, 1'b0, 16'h0, 16'h0);
    send(1, alu_cmd_t'(5'd30), 1'b1, 16'h0, 16'h0);
    send(1, ALU_NOP, 1'b0, 16'h0, 16'h0);
    idle();
    drain();
    check("undef_d", got_q[0].d, 0);
    check("undef_keep", got_q[1].d, 10);
    check("undef_clr_d", got_q[2].d, 0);
    check("undef_clr_acc", got_q[3].d, 0);

    // Reset in the middle of a burst
    send(0, ALU_ADM1, 1'b0, 16'd5, 16'h0);
    send(0, ALU_ADM1, 1'b0, 16'd5, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_d", d_out, 0);
    check("mid_rst_ready", ready_out, 1);
    valid_in = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_got();
    send(0, ALU_NOP, 1'b0, 16'h0, 16'h0);
    idle();
    drain();
    check("post_rst_nop", got_q[0].d, 0);
    check("post_rst_count", got_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
